// File: rtl/calc_key_entry.sv
// calc_key_entry: key-strobe front end of the calculator.
// Turns single-cycle key strobes into two 4-digit BCD operands (A, B),
// the operation select ST_L and the top-level calculator state ST.
// Every output is registered, so a key strobed in cycle n is visible in cycle n+1.

`ifndef S_A
`define S_A   2'd0
`endif
`ifndef S_B
`define S_B   2'd1
`endif
`ifndef S_OBL
`define S_OBL 2'd2
`endif
`ifndef SL_ADD
`define SL_ADD 3'd0
`endif
`ifndef SL_SUB
`define SL_SUB 3'd1
`endif
`ifndef SL_XOR
`define SL_XOR 3'd2
`endif
`ifndef SL_AND
`define SL_AND 3'd3
`endif
`ifndef SL_OR
`define SL_OR  3'd4
`endif

module calc_key_entry #(
    parameter int MAX_DIGITS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [4:0] key_code,
    output logic [3:0] A1,
    output logic [3:0] A2,
    output logic [3:0] A3,
    output logic [3:0] A4,
    output logic [3:0] B1,
    output logic [3:0] B2,
    output logic [3:0] B3,
    output logic [3:0] B4,
    output logic [1:0] ST,
    output logic [2:0] ST_L,
    output logic [2:0] digit_cnt,
    output logic       key_err
);

    // Calculator states; the fourth encoding is never entered.
    typedef enum logic [1:0] {
        ST_A   = `S_A,
        ST_B   = `S_B,
        ST_OBL = `S_OBL
    } state_e;

    // Key codes that are not digits.
    localparam logic [4:0] KEY_ADD   = 5'd16;
    localparam logic [4:0] KEY_OR    = 5'd20;
    localparam logic [4:0] KEY_EQ    = 5'd21;
    localparam logic [4:0] KEY_CLEAR = 5'd22;
    localparam logic [4:0] KEY_BKSP  = 5'd23;

    // Digit capacity clamped into the counter width; legal values are 1..4.
    localparam logic [2:0] MAX_CNT = 3'(MAX_DIGITS);

    // Operands stored as packed nibble vectors; index 0 is the least significant digit.
    logic [3:0][3:0] a_q, a_d;
    logic [3:0][3:0] b_q, b_d;
    state_e          st_q, st_d;
    logic [2:0]      stl_q, stl_d;
    logic [2:0]      cnt_q, cnt_d;
    logic            err_q, err_d;

    // Key classification.
    logic is_digit;
    logic is_op;
    logic is_eq;
    logic is_clear;
    logic is_bksp;

    // The operand currently being edited and its shifted variants.
    logic [3:0][3:0] act_q;
    logic [3:0][3:0] act_shl;
    logic [3:0][3:0] act_shr;
    logic            can_push;
    logic            can_pop;
    logic            editing;

    // Decode the strobed key into its class.
    always_comb begin
        is_digit = (key_code <= 5'd9);
        is_op    = (key_code >= KEY_ADD) && (key_code <= KEY_OR);
        is_eq    = (key_code == KEY_EQ);
        is_clear = (key_code == KEY_CLEAR);
        is_bksp  = (key_code == KEY_BKSP);
    end

    // Pick the active operand and precompute its digit-entry and backspace shifts.
    always_comb begin
        editing  = (st_q == ST_A) || (st_q == ST_B);
        act_q    = (st_q == ST_B) ? b_q : a_q;
        act_shl  = {act_q[2:0], key_code[3:0]};
        act_shr  = {4'd0, act_q[3:1]};
        can_push = editing && (cnt_q < MAX_CNT);
        can_pop  = editing && (cnt_q != 3'd0);
    end

    // Next-state logic: apply one key per strobe; a rejected key only raises err_d.
    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        st_d  = st_q;
        stl_d = stl_q;
        cnt_d = cnt_q;
        err_d = 1'b0;

        if (key_valid) begin
            if (is_clear) begin
                // CLEAR is accepted everywhere and mirrors reset.
                a_d   = '0;
                b_d   = '0;
                st_d  = ST_A;
                stl_d = `SL_ADD;
                cnt_d = 3'd0;
            end else if (is_digit) begin
                if (st_q == ST_OBL) begin
                    // A digit after a result starts a fresh calculation.
                    a_d   = {4'd0, 4'd0, 4'd0, key_code[3:0]};
                    b_d   = '0;
                    stl_d = `SL_ADD;
                    cnt_d = 3'd1;
                    st_d  = ST_A;
                end else if (can_push) begin
                    if (st_q == ST_B) begin
                        b_d = act_shl;
                    end else begin
                        a_d = act_shl;
                    end
                    cnt_d = cnt_q + 3'd1;
                end else begin
                    err_d = 1'b1;
                end
            end else if (is_bksp) begin
                if (can_pop) begin
                    if (st_q == ST_B) begin
                        b_d = act_shr;
                    end else begin
                        a_d = act_shr;
                    end
                    cnt_d = cnt_q - 3'd1;
                end else begin
                    err_d = 1'b1;
                end
            end else if (is_op) begin
                // Op codes 16..20 map directly onto the select encodings 0..4.
                if (st_q == ST_A) begin
                    stl_d = key_code[2:0];
                    b_d   = '0;
                    cnt_d = 3'd0;
                    st_d  = ST_B;
                end else if (st_q == ST_B) begin
                    stl_d = key_code[2:0];
                end else begin
                    err_d = 1'b1;
                end
            end else if (is_eq) begin
                if (st_q == ST_B) begin
                    st_d  = ST_OBL;
                    cnt_d = 3'd0;
                end else begin
                    err_d = 1'b1;
                end
            end else begin
                // Codes 10..15 and 24..31 are illegal.
                err_d = 1'b1;
            end
        end
    end

    // State register with asynchronous return to the reset values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            st_q  <= ST_A;
            stl_q <= `SL_ADD;
            cnt_q <= 3'd0;
            err_q <= 1'b0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            st_q  <= st_d;
            stl_q <= stl_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign A1 = a_q[0];
    assign A2 = a_q[1];
    assign A3 = a_q[2];
    assign A4 = a_q[3];
    assign B1 = b_q[0];
    assign B2 = b_q[1];
    assign B3 = b_q[2];
    assign B4 = b_q[3];

    assign ST        = st_q;
    assign ST_L      = stl_q;
    assign digit_cnt = cnt_q;
    assign key_err   = err_q;

endmodule

// File: tb/tb_calc_key_entry.sv
// Directed bench for calc_key_entry: a default (4-digit) instance and a 2-digit instance.
module tb_calc_key_entry;

    localparam logic [1:0] TS_A   = 2'd0;
    localparam logic [1:0] TS_B   = 2'd1;
    localparam logic [1:0] TS_OBL = 2'd2;
    localparam logic [2:0] TL_ADD = 3'd0;
    localparam logic [2:0] TL_SUB = 3'd1;
    localparam logic [2:0] TL_XOR = 3'd2;

    localparam logic [4:0] K_ADD = 5'd16, K_SUB = 5'd17, K_XOR = 5'd18, K_OR = 5'd20;
    localparam logic [4:0] K_EQ = 5'd21, K_CLR = 5'd22, K_BS = 5'd23;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_valid = 1'b0;
    logic [4:0] key_code = 5'd0;
    logic       key_valid2 = 1'b0;
    logic [4:0] key_code2 = 5'd0;

    logic [3:0] a1, a2, a3, a4, b1, b2, b3, b4;
    logic [1:0] st;
    logic [2:0] stl, cnt;
    logic       err;

    logic [3:0] c1, c2, c3, c4, d1, d2, d3, d4;
    logic [1:0] st2;
    logic [2:0] stl2, cnt2;
    logic       err2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    calc_key_entry dut (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
        .A1(a1), .A2(a2), .A3(a3), .A4(a4),
        .B1(b1), .B2(b2), .B3(b3), .B4(b4),
        .ST(st), .ST_L(stl), .digit_cnt(cnt), .key_err(err)
    );

    calc_key_entry #(.MAX_DIGITS(2)) dut2 (
        .clk(clk), .rst(rst), .key_valid(key_valid2), .key_code(key_code2),
        .A1(c1), .A2(c2), .A3(c3), .A4(c4),
        .B1(d1), .B2(d2), .B3(d3), .B4(d4),
        .ST(st2), .ST_L(stl2), .digit_cnt(cnt2), .key_err(err2)
    );

    function automatic logic [15:0] opa();
        return {a4, a3, a2, a1};
    endfunction

    function automatic logic [15:0] opb();
        return {b4, b3, b2, b1};
    endfunction

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One-cycle strobe on the 4-digit instance; returns at the following negedge.
    task automatic press(input logic [4:0] code);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = code;
        @(negedge clk);
        key_valid = 1'b0;
        $display("key %0d: A=%h B=%h ST=%0d ST_L=%0d cnt=%0d err=%0b",
                 code, opa(), opb(), st, stl, cnt, err);
    endtask

    task automatic press2(input logic [4:0] code);
        @(negedge clk);
        key_valid2 = 1'b1;
        key_code2  = code;
        @(negedge clk);
        key_valid2 = 1'b0;
        $display("key2 %0d: A=%h cnt=%0d err=%0b", code, {c4, c3, c2, c1}, cnt2, err2);
    endtask

    task automatic idle();
        @(negedge clk);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".A"}, opa(), 16'h0000);
        chk({tag, ".B"}, opb(), 16'h0000);
        chk({tag, ".ST"}, 16'(st), 16'(TS_A));
        chk({tag, ".STL"}, 16'(stl), 16'(TL_ADD));
        chk({tag, ".cnt"}, 16'(cnt), 16'd0);
        chk({tag, ".err"}, 16'(err), 16'd0);
    endtask

    initial begin
        // Power-on reset
        repeat (2) @(negedge clk);
        rst = 1'b0;
        idle();
        chk_reset("por");

        // Fill A with 1,2,3,4
        press(5'd1); chk("d1.err", 16'(err), 16'd0);
        press(5'd2); chk("d2.err", 16'(err), 16'd0);
        press(5'd3); chk("d3.err", 16'(err), 16'd0);
        press(5'd4); chk("d4.err", 16'(err), 16'd0);
        chk("fill.A", opa(), 16'h1234);
        chk("fill.cnt", 16'(cnt), 16'd4);
        chk("fill.ST", 16'(st), 16'(TS_A));

        // Fifth digit rejected for one cycle only
        press(5'd5);
        chk("over.err", 16'(err), 16'd1);
        chk("over.A", opa(), 16'h1234);
        chk("over.cnt", 16'(cnt), 16'd4);
        idle();
        chk("over.err_drop", 16'(err), 16'd0);

        press(K_BS);
        chk("bs.A", opa(), 16'h0123);
        chk("bs.cnt", 16'(cnt), 16'd3);
        chk("bs.err", 16'(err), 16'd0);

        // CLEAR from mid-entry
        press(K_CLR);
        chk_reset("clr");

        // Backspace on an empty operand
        press(K_BS);
        chk("bs0.err", 16'(err), 16'd1);
        chk("bs0.cnt", 16'(cnt), 16'd0);

        // 42 SUB XOR 7 =
        press(5'd4);
        press(5'd2);
        chk("a42.A", opa(), 16'h0042);
        chk("a42.cnt", 16'(cnt), 16'd2);
        press(K_SUB);
        chk("sub.ST", 16'(st), 16'(TS_B));
        chk("sub.STL", 16'(stl), 16'(TL_SUB));
        chk("sub.cnt", 16'(cnt), 16'd0);
        press(K_XOR);
        chk("xor.STL", 16'(stl), 16'(TL_XOR));
        chk("xor.ST", 16'(st), 16'(TS_B));
        chk("xor.err", 16'(err), 16'd0);
        press(5'd7);
        chk("b7.B", opb(), 16'h0007);
        chk("b7.cnt", 16'(cnt), 16'd1);
        press(K_EQ);
        chk("eq.ST", 16'(st), 16'(TS_OBL));
        chk("eq.cnt", 16'(cnt), 16'd0);
        chk("eq.A", opa(), 16'h0042);
        chk("eq.B", opb(), 16'h0007);
        chk("eq.STL", 16'(stl), 16'(TL_XOR));

        // Keys rejected while showing a result
        press(K_OR);
        chk("obl_or.err", 16'(err), 16'd1);
        chk("obl_or.STL", 16'(stl), 16'(TL_XOR));
        chk("obl_or.ST", 16'(st), 16'(TS_OBL));
        press(K_EQ);
        chk("obl_eq.err", 16'(err), 16'd1);
        chk("obl_eq.ST", 16'(st), 16'(TS_OBL));
        press(K_BS);
        chk("obl_bs.err", 16'(err), 16'd1);
        chk("obl_bs.B", opb(), 16'h0007);
        chk("obl_bs.A", opa(), 16'h0042);
        idle();
        chk("obl.err_drop", 16'(err), 16'd0);

        // A digit in the result state starts a new calculation
        press(5'd9);
        chk("new.A", opa(), 16'h0009);
        chk("new.B", opb(), 16'h0000);
        chk("new.STL", 16'(stl), 16'(TL_ADD));
        chk("new.cnt", 16'(cnt), 16'd1);
        chk("new.ST", 16'(st), 16'(TS_A));
        chk("new.err", 16'(err), 16'd0);

        // Illegal codes and EQUALS in S_A
        press(5'd12);
        chk("ill12A.err", 16'(err), 16'd1);
        chk("ill12A.A", opa(), 16'h0009);
        press(5'd30);
        chk("ill30A.err", 16'(err), 16'd1);
        chk("ill30A.cnt", 16'(cnt), 16'd1);
        press(K_EQ);
        chk("eqA.err", 16'(err), 16'd1);
        chk("eqA.ST", 16'(st), 16'(TS_A));

        // ADD with an empty A
        press(K_CLR);
        press(K_ADD);
        chk("add0.ST", 16'(st), 16'(TS_B));
        chk("add0.A", opa(), 16'h0000);
        chk("add0.STL", 16'(stl), 16'(TL_ADD));
        chk("add0.err", 16'(err), 16'd0);

        // Illegal codes in S_B
        press(5'd12);
        chk("ill12B.err", 16'(err), 16'd1);
        chk("ill12B.ST", 16'(st), 16'(TS_B));
        press(5'd30);
        chk("ill30B.err", 16'(err), 16'd1);
        chk("ill30B.cnt", 16'(cnt), 16'd0);

        // Leading zero counts, then async reset mid B entry
        press(5'd0);
        press(5'd5);
        chk("b05.B", opb(), 16'h0005);
        chk("b05.cnt", 16'(cnt), 16'd2);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk_reset("arst");
        @(negedge clk);
        rst = 1'b0;
        idle();
        chk_reset("arst_post");

        // CLEAR while showing a result
        press(5'd3);
        press(K_ADD);
        press(5'd4);
        press(K_EQ);
        chk("pre_clr.ST", 16'(st), 16'(TS_OBL));
        press(K_CLR);
        chk_reset("clr_obl");

        // Two-digit instance: third digit rejected
        press2(5'd7);
        press2(5'd8);
        chk("m2.A", {c4, c3, c2, c1}, 16'h0078);
        chk("m2.cnt", 16'(cnt2), 16'd2);
        press2(5'd9);
        chk("m2_over.err", 16'(err2), 16'd1);
        chk("m2_over.A", {c4, c3, c2, c1}, 16'h0078);
        chk("m2_over.cnt", 16'(cnt2), 16'd2);
        press2(K_BS);
        chk("m2_bs.A", {c4, c3, c2, c1}, 16'h0007);
        chk("m2_bs.err", 16'(err2), 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
